// File: rtl/simple_pkg.sv
// Shared word/pointer types and default sizing for the simple_* datapath.
package simple_pkg;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 16;
    localparam int FIFO_AW = $clog2(DEPTH);

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [FIFO_AW:0] ptr_t;

endpackage

// File: rtl/simple_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write port, combinational read port, no reset on the array.
module simple_fifo_mem #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/simple_stream_fifo.sv
// Show-ahead stream FIFO behind the simple_pkg register stage.
// Optional almost_full/almost_empty outputs under SIMPLE_STREAM_FIFO_ALMOST_EN.
module simple_stream_fifo
    import simple_pkg::*;
#(
    parameter  int WIDTH = simple_pkg::WIDTH,
    parameter  int DEPTH = simple_pkg::DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    input  word_t       in_data,
    output logic        in_ready,
    output logic        out_valid,
    output word_t       out_data,
    input  logic        out_ready,
    output logic [AW:0] count,
`ifdef SIMPLE_STREAM_FIFO_ALMOST_EN
    output logic        almost_full,
    output logic        almost_empty,
`endif
    output logic        overflow
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("simple_stream_fifo: DEPTH must be a power of two and at least 2");
    end
    if (WIDTH != $bits(word_t)) begin : g_width_check
        $error("simple_stream_fifo: WIDTH must match simple_pkg::word_t");
    end

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW:0]   count_next;
    logic          full, empty, push, pop;
    logic [WIDTH-1:0] rdata;

    // Handshake: a word moves when valid & ready at a rising edge. in_ready and
    // out_valid come from registered pointers only, never from in_valid/out_ready.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = empty ? '0 : rdata;

    simple_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && !clear),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            count <= count_next;
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef SIMPLE_STREAM_FIFO_ALMOST_EN
    localparam logic [AW:0] ALMOST_FULL_LVL = (AW+1)'(DEPTH - 2);

    // Registered from count_next so the flags always agree with count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else if (clear) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_next >= ALMOST_FULL_LVL);
            almost_empty <= (count_next <= (AW+1)'(1));
        end
    end
`endif

endmodule

// File: tb/tb_simple_stream_fifo.sv
// Self-checking bench for simple_stream_fifo against a queue-based reference model.
// Connects almost_full/almost_empty when SIMPLE_STREAM_FIFO_ALMOST_EN is defined.
module tb_simple_stream_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [AW:0]      count;
    logic             overflow;
`ifdef SIMPLE_STREAM_FIFO_ALMOST_EN
    logic             almost_full;
    logic             almost_empty;
`endif

    logic [WIDTH-1:0] exp_q[$];
    logic             exp_ovf;
    int               tests_run = 0;
    int               tests_failed = 0;

    simple_stream_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
`ifdef SIMPLE_STREAM_FIFO_ALMOST_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, ".count"},     32'(count),     32'(n));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(n < DEPTH));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(n > 0));
        chk({tag, ".out_data"},  32'(out_data),  (n > 0) ? 32'(exp_q[0]) : 32'h0);
        chk({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
`ifdef SIMPLE_STREAM_FIFO_ALMOST_EN
        chk({tag, ".almost_full"},  32'(almost_full),  32'(n >= DEPTH - 2));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 1));
`endif
    endtask

    // Drive one cycle, advance the model on the edge, check 1 time unit later.
    task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d,
                        input logic r, input logic c);
        int  n;
        logic do_push, do_pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
        @(posedge clk);
        n = exp_q.size();
        if (c) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            do_pop  = r && (n > 0);
            do_push = v && (n < DEPTH);
            if (v && n == DEPTH) exp_ovf = 1'b1;
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        exp_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        step("idle", 0, 8'h00, 0, 0);

        // Single word latency and pop
        step("push_a5", 1, 8'hA5, 0, 0);
        step("hold_a5", 0, 8'h00, 0, 0);
        step("pop_a5",  0, 8'h00, 1, 0);

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 8'(i), 0, 0);
        step("ovf_ff", 1, 8'hFF, 0, 0);
        for (int i = 0; i < DEPTH; i++) step("drain", 0, 8'h00, 1, 0);
        step("clr1", 0, 8'h00, 0, 1);

        // Full with simultaneous push attempt and pop
        for (int i = 0; i < DEPTH; i++) step("fill2", 1, 8'(i), 0, 0);
        step("full_pop", 1, 8'h55, 1, 0);
        chk("full_pop.head", 32'(out_data), 32'h01);
        step("clr2", 0, 8'h00, 0, 1);

        // Continuous streaming across two pointer wraps
        for (int i = 0; i < 40; i++) step("stream", 1, 8'(8'h10 + i), 1, 0);
        step("stream_end", 0, 8'h00, 1, 0);

        // Clear with concurrent push, then almost_full level
        for (int i = 0; i < 5; i++) step("load5", 1, 8'(8'h80 + i), 0, 0);
        step("clr_push", 1, 8'h99, 0, 1);
        for (int i = 0; i < DEPTH - 2; i++) step("load14", 1, 8'(8'h40 + i), 0, 0);

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_ovf = 1'b0;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 0, 8'h00, 0, 0);

        // Randomized traffic with occasional clear
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 99) < 60), 8'($urandom),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/simple_stream_fifo.md
Name: simple_stream_fifo

Overview:
Buffer stage directly downstream of the simple_pkg register stage. It accepts registered WIDTH-bit words over a valid/ready handshake and stores up to DEPTH of them. It presents them in order on a show-ahead (first-word-fall-through) valid/ready output. Width and depth come from simple_pkg.

Parameters:
- WIDTH, default simple_pkg::WIDTH (8): data word width in bits.
- DEPTH, default simple_pkg::DEPTH (16): number of entries. Must be a power of two and at least 2; an elaboration-time check fails otherwise.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word present.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  space available (not full).
- out_valid  output  1  head word available (not empty).
- out_data  output  WIDTH  head word (show-ahead).
- out_ready  input  1  downstream accepts head word.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: in_valid was asserted while full.
- clear  input  1  synchronous flush.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - wr_ptr, rd_ptr, count and overflow go to 0.
  - Outputs: in_ready = 1, out_valid = 0.
  - out_data reads as '0 while empty: muxed to zero, storage is not reset.
- Reset mid-operation discards all contents immediately. The storage array keeps stale data, but it is never visible.
- Pointers are $clog2(DEPTH)+1 bits, with the extra MSB used as a wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = address bits equal and MSBs differ.
- Handshakes:
  - Push = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - in_ready = !full; out_valid = !empty. Both are derived from registered pointers only, so there is no combinational path from in_valid or out_ready.
- Push writes in_data to mem[wr_ptr addr] and increments wr_ptr, modulo 2*DEPTH.
- Pop increments rd_ptr.
- out_data = mem[rd_ptr addr], read combinationally (show-ahead).
- Latency: a word pushed at edge N appears on out_data/out_valid after edge N when the FIFO was empty (one cycle).
- Full plus pop in the same cycle: in_ready is still 0, so no push occurs and count decreases by 1. Full-and-pop bypass is deliberately unsupported.
- Empty: out_valid = 0, so no pop can occur. A push that cycle makes count = 1.
- Simultaneous push and pop when neither full nor empty: count is unchanged and both pointers advance.
- Pointer wrap: after entry DEPTH-1 the address returns to 0 and the MSB toggles.
- overflow sets on any cycle with in_valid & full. It clears only on reset or clear.
- clear = 1 at an edge:
  - Pointers, count and overflow go to 0.
  - Any push or pop that cycle is ignored.
  - clear has priority over all other updates.

Optional Feature:
- Macro: SIMPLE_STREAM_FIFO_ALMOST_EN.
- Defined:
  - Adds outputs almost_full, asserted when count >= DEPTH-2.
  - Adds almost_empty, asserted when count <= 1.
  - Both are registered, updated with count, reset to almost_full = 0 and almost_empty = 1, and forced to those values by clear.
- Undefined: the ports and logic are absent and the remaining behaviour is identical.

Decomposition:
- simple_pkg gains:
  - typedef word_t = logic [WIDTH-1:0].
  - localparam FIFO_AW = $clog2(DEPTH).
  - typedef ptr_t = logic [FIFO_AW:0].
  - Module ports use word_t.
- One sub-module, simple_fifo_mem:
  - DEPTH x WIDTH storage with a synchronous write port (we, waddr, wdata) and a combinational read port (raddr, rdata).
  - No reset on the array.
- Pointer, count and flag logic stays in simple_stream_fifo.

Test Plan:
- Reset, then idle: in_ready = 1, out_valid = 0, count = 0, overflow = 0, out_data = 0x00.
- Push 0xA5 with out_ready = 0: next cycle out_valid = 1, out_data = 0xA5, count = 1. Raise out_ready for one cycle: count = 0, out_valid = 0.
- Push 16 words 0x00..0x0F with no pops: count = 16, in_ready = 0.
  - A 17th in_valid (0xFF): overflow = 1, data not stored.
  - Drain yields 0x00..0x0F in order.
- Fill to 16, then assert in_valid = 1 (0x55) and out_ready = 1 for the same cycle: count = 15, head advances to 0x01, 0x55 not stored.
- Stream 40 words 0x10..0x37 with in_valid = out_ready = 1 continuously: pointers wrap twice, output order matches input, count stays 1 after the first word.
- Load 5 words, assert clear together with in_valid: count = 0, out_valid = 0, overflow = 0. With ALMOST_EN: almost_empty = 1; at count = 14, almost_full = 1.
